memory_interface: RTL and testbench

//   Word-addressed main memory plus access sequencer directly downstream of the datapath MAR/MDR.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mem_array.sv | 28 ++
 rtl/memory_interface.sv | 161 ++++++++++++++++
 tb/tb_memory_interface.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and default constants shared by the CPU memory path.
// Holds the memory sequencer state encoding and the default memory geometry and timing.
// No ports; imported by memory_interface.
package cpu_pkg;

   // Memory access sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } mem_state_t;

   localparam int MEM_BITS        = 32;
   localparam int MEM_ADDR_BITS   = 9;
   localparam int MEM_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with a registered read port.
// Ports: clk; we (write enable); addr (word address); din (write data);
//        dout (read data, valid the cycle after addr is presented). Contents are not reset.
module mem_array #(
   parameter int BITS      = 32,
   parameter int ADDR_BITS = 9
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [BITS-1:0]      din,
   output logic [BITS-1:0]      dout
);

   logic [BITS-1:0] r_mem [2**ADDR_BITS];
   logic [BITS-1:0] r_dout;

   // Read-before-write: a write cycle returns the old word on dout.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= din;
      end
      r_dout <= r_mem[addr];
   end

   assign dout = r_dout;

endmodule

// File: rtl/memory_interface.sv
// memory_interface: word-addressed main memory plus access sequencer (IDLE -> WAIT -> ACCESS -> DONE).
// Ports: clk, reset (async, active high); addr, wdata, rd_req, wr_req from datapath/control;
//        rdata, done, busy, err back to the datapath. done rises WAIT_CYCLES+2 edges after the
//        accept edge; busy spans WAIT_CYCLES+3 cycles. Requests are only sampled in IDLE.
// Option: define MEM_BOUNDS_CHECK_EN to flag (err) and suppress accesses with nonzero upper address bits.
module memory_interface
   import cpu_pkg::*;
#(
   parameter int BITS        = MEM_BITS,
   parameter int ADDR_BITS   = MEM_ADDR_BITS,
   parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BITS-1:0] addr,
   input  logic [BITS-1:0] wdata,
   input  logic            rd_req,
   input  logic            wr_req,
   output logic [BITS-1:0] rdata,
   output logic            done,
   output logic            busy,
   output logic            err
);

   localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   mem_state_t           r_state;
   mem_state_t           w_next;
   logic [CW-1:0]        r_cnt;
   logic                 r_op_rd;
   logic [ADDR_BITS-1:0] r_addr_lo;
   logic [BITS-1:0]      r_wdata;
   logic [BITS-1:0]      r_rdata;
   logic                 r_done;
   logic                 r_busy;
   logic                 w_accept;
   logic                 w_oob;
   logic                 w_we;
   logic [BITS-1:0]      w_dout;

   // Next-state logic. A request while not IDLE is simply not looked at.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE: begin
            if (rd_req || wr_req) begin
               w_accept = 1'b1;
               w_next   = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == CNT_LAST) begin
               w_next = ACCESS;
            end
         end
         ACCESS:  w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Wait-state counter: 0..WAIT_CYCLES-1 while in WAIT, parked at 0 otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == WAIT && r_cnt != CNT_LAST) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   // Request latches; everything downstream of the accept edge uses these copies.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op_rd   <= 1'b0;
         r_addr_lo <= '0;
         r_wdata   <= '0;
      end else if (w_accept) begin
         r_op_rd   <= rd_req;           // read wins when both strobes are high
         r_addr_lo <= addr[ADDR_BITS-1:0];
         r_wdata   <= wdata;
      end
   end

`ifdef MEM_BOUNDS_CHECK_EN
   logic [BITS-ADDR_BITS-1:0] r_addr_hi;
   logic                      r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr_hi <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr_hi <= addr[BITS-1:ADDR_BITS];
         end
         r_err <= (r_state == DONE) && w_oob;
      end
   end

   assign w_oob = |r_addr_hi;
   assign err   = r_err;
`else
   // Upper address bits alias onto the implemented array.
   logic w_unused_addr_hi;
   assign w_unused_addr_hi = ^addr[BITS-1:ADDR_BITS];
   assign w_oob            = 1'b0;
   assign err              = 1'b0;
`endif

   // The array sees the latched address continuously; only the write enable is gated.
   // The registered read launched by the ACCESS exit edge is on w_dout throughout DONE.
   assign w_we = (r_state == ACCESS) && !r_op_rd && !w_oob;

   mem_array #(
      .BITS      (BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_mem_array (
      .clk  (clk),
      .we   (w_we),
      .addr (r_addr_lo),
      .din  (r_wdata),
      .dout (w_dout)
   );

   // Handshake outputs are registered off the DONE state, so done/rdata/err change together.
   // busy is set on accept and dropped with done; an accept in the same edge keeps it high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= (r_state == DONE);
         if (r_state == DONE && r_op_rd) begin
            r_rdata <= w_oob ? '0 : w_dout;
         end
         if (w_accept) begin
            r_busy <= 1'b1;
         end else if (r_done) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign rdata = r_rdata;
   assign done  = r_done;
   assign busy  = r_busy;

endmodule

// File: tb/tb_memory_interface.sv
// tb_memory_interface: scoreboard bench for memory_interface, two instances
// (WAIT_CYCLES=2 and WAIT_CYCLES=0) driven one at a time. Expected responses come from an
// array-based memory model and are popped by a monitor on the cycle done is due.
`timescale 1ns/1ps
module tb_memory_interface;

   localparam int W0 = 2;
   localparam int W1 = 0;
`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   typedef struct {
      int          d;
      logic [31:0] rdata;
      bit          err;
      int          due;
   } exp_t;

   logic             clk   = 1'b0;
   logic             reset = 1'b1;
   logic [1:0][31:0] addr;
   logic [1:0][31:0] wdata;
   logic [1:0][31:0] rdata;
   logic [1:0]       rd_req;
   logic [1:0]       wr_req;
   logic [1:0]       done;
   logic [1:0]       busy;
   logic [1:0]       err;

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          run [2];
   exp_t        q [$];
   exp_t        mon_e;
   bit          due_now;
   logic [31:0] mem_m [2][512];
   logic [31:0] rd_m [2];
   logic [8:0]  pool [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   memory_interface #(.BITS(32), .ADDR_BITS(9), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .reset(reset), .addr(addr[0]), .wdata(wdata[0]),
      .rd_req(rd_req[0]), .wr_req(wr_req[0]), .rdata(rdata[0]),
      .done(done[0]), .busy(busy[0]), .err(err[0]));

   memory_interface #(.BITS(32), .ADDR_BITS(9), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .reset(reset), .addr(addr[1]), .wdata(wdata[1]),
      .rd_req(rd_req[1]), .wr_req(wr_req[1]), .rdata(rdata[1]),
      .done(done[1]), .busy(busy[1]), .err(err[1]));

   function automatic int wc(int d);
      return (d == 0) ? W0 : W1;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got 0x%08h, required 0x%08h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: done must be high exactly on the due cycle of the oldest outstanding access.
   always @(negedge clk) begin
      if (reset) begin
         run[0] = 0;
         run[1] = 0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            due_now = (q.size() > 0) && (q[0].d == d) && (q[0].due == cyc);
            check($sformatf("done_dut%0d", d), 32'(done[d]), 32'(due_now));
            if (due_now) begin
               mon_e = q.pop_front();
               check($sformatf("rdata_dut%0d", d), rdata[d], mon_e.rdata);
               check($sformatf("err_dut%0d", d), 32'(err[d]), 32'(mon_e.err));
            end else begin
               check($sformatf("err_idle_dut%0d", d), 32'(err[d]), 32'd0);
            end
            if (busy[d]) begin
               run[d]++;
            end else if (run[d] != 0) begin
               check($sformatf("busy_len_dut%0d", d), 32'(run[d]), 32'(wc(d) + 3));
               run[d] = 0;
            end
         end
      end
   end

   // Issue one access once the DUT is idle; returns just after the accept edge.
   task automatic do_op(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] wd);
      int         n;
      logic [8:0] idx;
      bit         oob;
      exp_t       e;
      n = 0;
      while (busy[d] && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (busy[d]) check("idle_wait", 32'(busy[d]), 32'd0);
      idx = a[8:0];
      oob = BC && (a[31:9] != 23'd0);
      if (rd) begin
         rd_m[d] = oob ? 32'd0 : mem_m[d][idx];
      end else if (!oob) begin
         mem_m[d][idx] = wd;
      end
      e.d     = d;
      e.rdata = rd_m[d];
      e.err   = oob;
      e.due   = cyc + 1 + wc(d) + 2;
      q.push_back(e);
      addr[d]   = a;
      wdata[d]  = wd;
      rd_req[d] = rd;
      wr_req[d] = wr;
      @(posedge clk); #1;
      check("accept_busy", 32'(busy[d]), 32'd1);
      rd_req[d] = 1'b0;
      wr_req[d] = 1'b0;
      addr[d]   = $urandom;   // latched copies must be used from here on
      wdata[d]  = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || busy != 2'b00) && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_rdata_dut%0d", d), rdata[d], 32'd0);
         check($sformatf("rst_done_dut%0d", d), 32'(done[d]), 32'd0);
         check($sformatf("rst_busy_dut%0d", d), 32'(busy[d]), 32'd0);
         check($sformatf("rst_err_dut%0d", d), 32'(err[d]), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200us");
      $fatal(1);
   end

   initial begin
      logic [31:0] old;
      logic [31:0] a;
      int          k;
      int          op;
      addr   = '0;
      wdata  = '0;
      rd_req = '0;
      wr_req = '0;
      rd_m[0] = 32'd0;
      rd_m[1] = 32'd0;
      pool = '{9'h000, 9'h001, 9'h0FF, 9'h100, 9'h1FF, 9'h0A3, 9'h155, 9'h07E};

      // Reset state
      @(negedge clk);
      check_reset_outputs();
      #1 reset = 1'b0;

      // 1: reset in the middle of a write's wait states
      do_op(0, 1'b0, 1'b1, 32'h10, 32'h11111111);
      wait_idle();
      old = mem_m[0][9'h010];
      do_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk); #1;
      reset = 1'b1;
      q.delete();
      mem_m[0][9'h010] = old;
      rd_m[0] = 32'd0;
      rd_m[1] = 32'd0;
      @(negedge clk);
      check_reset_outputs();
      @(negedge clk);
      check_reset_outputs();
      #1 reset = 1'b0;
      do_op(0, 1'b1, 1'b0, 32'h10, 32'h0);

      // 2: write then read at 0x1A5
      do_op(0, 1'b0, 1'b1, 32'h1A5, 32'h12345678);
      do_op(0, 1'b1, 1'b0, 32'h1A5, 32'h0);

      // 4: read/write contention, then a request pulse while busy
      do_op(0, 1'b0, 1'b1, 32'h007, 32'hA5A5A5A5);
      do_op(0, 1'b1, 1'b1, 32'h007, 32'hFFFFFFFF);
      do_op(0, 1'b1, 1'b0, 32'h007, 32'h0);
      @(negedge clk); #1;
      rd_req[0] = 1'b1;
      @(negedge clk); #1;
      rd_req[0] = 1'b0;
      do_op(0, 1'b1, 1'b0, 32'h007, 32'h0);

      // 5: out-of-range / aliasing address
      do_op(0, 1'b0, 1'b1, 32'h005, 32'h55555555);
      do_op(0, 1'b0, 1'b1, 32'h00000205, 32'hCAFEF00D);
      do_op(0, 1'b1, 1'b0, 32'h005, 32'h0);
      do_op(0, 1'b1, 1'b0, 32'h205, 32'h0);

      // Random traffic over a preloaded address pool, occasionally with upper bits set
      for (int i = 0; i < 8; i++) do_op(0, 1'b0, 1'b1, {23'd0, pool[i]}, $urandom);
      for (int i = 0; i < 30; i++) begin
         k  = $urandom_range(0, 7);
         op = $urandom_range(0, 2);
         a  = {23'd0, pool[k]};
         if ($urandom_range(0, 3) == 0) a[31:9] = 23'($urandom_range(1, 32'h7FFFFF));
         do_op(0, op != 1, op != 0, a, $urandom);
      end
      wait_idle();

      // 3: zero wait states on the second instance
      do_op(1, 1'b0, 1'b1, 32'h003, 32'h0BADCAFE);
      do_op(1, 1'b1, 1'b0, 32'h003, 32'h0);
      for (int i = 0; i < 8; i++) do_op(1, 1'b0, 1'b1, {23'd0, pool[i]}, $urandom);
      for (int i = 0; i < 12; i++) begin
         k  = $urandom_range(0, 7);
         op = $urandom_range(0, 2);
         do_op(1, op != 1, op != 0, {23'd0, pool[k]}, $urandom);
      end
      wait_idle();
      repeat (4) @(negedge clk);
      check("queue_empty", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
